uart_tx_ctrl: RTL and testbench



---
 rtl/uart_tx_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: baud divider, TX FIFO with valid/ready push, and a framing FSM
// with configurable data width, parity and stop bits. Queued frames go out back-to-back.
module uart_tx_ctrl #(
   parameter int CLOCK_FREQ    = 100_000_000,
   parameter int BAUD_RATE     = 115_200,
   parameter int TICKS_PER_BIT = 16,
   parameter int DATA_WIDTH    = 8,
   parameter int FIFO_DEPTH    = 16,
   parameter int PARITY        = 0,
   parameter int STOP_BITS     = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [DATA_WIDTH-1:0]             s_data,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic                              tx_en,
   output logic                              tx_out,
   output logic                              tx_busy,
   output logic                              tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

   localparam int   DIV     = CLOCK_FREQ / (BAUD_RATE * TICKS_PER_BIT);
   localparam int   DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int   TICK_W  = $clog2(STOP_BITS * TICKS_PER_BIT + 1);
   localparam int   BIT_W   = $clog2(DATA_WIDTH + 1);
   localparam int   AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int   CW      = $clog2(FIFO_DEPTH + 1);
   localparam logic HAS_PAR = (PARITY != 0);
   localparam logic PAR_ODD = (PARITY == 2);

   if (DIV < 1) begin : g_err_div
      $error("uart_tx_ctrl: baud divider below 1");
   end
   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_err_dw
      $error("uart_tx_ctrl: DATA_WIDTH must be 5..9");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
      $error("uart_tx_ctrl: FIFO_DEPTH must be a power of two >= 2");
   end
   if (PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 || TICKS_PER_BIT < 1) begin : g_err_fmt
      $error("uart_tx_ctrl: illegal frame format");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [TICK_W-1:0]     tck_q, tck_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_out_q, line_d;
   logic                  done_p_q, done_p_d;
   logic                  done_q;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]         wr_q, rd_q;
   logic [CW-1:0]         cnt_q;

   logic push, pop, can_pop, baud_tick, bit_end, stop_end;

   assign s_ready   = !rst && (cnt_q < CW'(FIFO_DEPTH));
   assign push      = s_valid && s_ready;
   assign can_pop   = tx_en && (cnt_q != '0);
   assign baud_tick = (div_q == DIV_W'(DIV - 1));
   assign bit_end   = baud_tick && (tck_q == TICK_W'(TICKS_PER_BIT - 1));
   assign stop_end  = baud_tick && (tck_q == TICK_W'(STOP_BITS * TICKS_PER_BIT - 1));

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      tck_d    = tck_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      par_d    = par_q;
      done_p_d = 1'b0;
      pop      = 1'b0;
      line_d   = 1'b1;
      if (state_q != S_IDLE) begin
         div_d = baud_tick ? '0 : div_q + 1'b1;
         if (baud_tick) tck_d = tck_q + 1'b1;
      end
      case (state_q)
         S_IDLE: begin
            if (can_pop) pop = 1'b1;
         end
         S_START: begin
            line_d = 1'b0;
            if (bit_end) begin
               tck_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            line_d = shift_q[0];
            if (bit_end) begin
               tck_d   = '0;
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 1'b1;
               if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
                  bit_d   = '0;
                  state_d = HAS_PAR ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            line_d = par_q;
            if (bit_end) begin
               tck_d   = '0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (stop_end) begin
               done_p_d = 1'b1;
               tck_d    = '0;
               state_d  = S_IDLE;
               if (can_pop) pop = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A pop always starts a fresh frame with the divider realigned.
      if (pop) begin
         state_d = S_START;
         div_d   = '0;
         tck_d   = '0;
         bit_d   = '0;
         shift_d = mem_q[rd_q];
         par_d   = (^mem_q[rd_q]) ^ PAR_ODD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         div_q    <= '0;
         tck_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tx_out_q <= 1'b1;
         done_p_q <= 1'b0;
         done_q   <= 1'b0;
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         tck_q    <= tck_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tx_out_q <= line_d;
         done_p_q <= done_p_d;
         done_q   <= done_p_q;
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= s_data;
   end

   // The line is registered, so done/busy trail the FSM by one clock to stay aligned with it.
   assign tx_out     = tx_out_q;
   assign tx_done    = done_q;
   assign tx_busy    = (state_q != S_IDLE) || done_p_q;
   assign fifo_count = cnt_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four instances cover 8N1/depth 4, 8E1, 8O1 and 7N2,
// all at DIV=10 so each bit lasts 160 clocks.
module tb_uart_tx_ctrl;

   logic clk, rst;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] a_data, b_data, c_data;
   logic [6:0] d_data;
   logic a_valid, b_valid, c_valid, d_valid;
   logic a_ready, b_ready, c_ready, d_ready;
   logic a_en;
   logic a_tx, b_tx, c_tx, d_tx;
   logic a_busy, b_busy, c_busy, d_busy;
   logic a_done, b_done, c_done, d_done;
   logic [2:0] a_cnt;
   logic [4:0] b_cnt, c_cnt, d_cnt;

   logic [1:0] sel;
   logic line, done, busy;

   uart_tx_ctrl #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(10_000), .TICKS_PER_BIT(16),
                  .DATA_WIDTH(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst), .s_data(a_data), .s_valid(a_valid), .s_ready(a_ready),
      .tx_en(a_en), .tx_out(a_tx), .tx_busy(a_busy), .tx_done(a_done), .fifo_count(a_cnt));

   uart_tx_ctrl #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(10_000), .TICKS_PER_BIT(16),
                  .DATA_WIDTH(8), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1)) u_b (
      .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_ready(b_ready),
      .tx_en(1'b1), .tx_out(b_tx), .tx_busy(b_busy), .tx_done(b_done), .fifo_count(b_cnt));

   uart_tx_ctrl #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(10_000), .TICKS_PER_BIT(16),
                  .DATA_WIDTH(8), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(1)) u_c (
      .clk(clk), .rst(rst), .s_data(c_data), .s_valid(c_valid), .s_ready(c_ready),
      .tx_en(1'b1), .tx_out(c_tx), .tx_busy(c_busy), .tx_done(c_done), .fifo_count(c_cnt));

   uart_tx_ctrl #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(10_000), .TICKS_PER_BIT(16),
                  .DATA_WIDTH(7), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(2)) u_d (
      .clk(clk), .rst(rst), .s_data(d_data), .s_valid(d_valid), .s_ready(d_ready),
      .tx_en(1'b1), .tx_out(d_tx), .tx_busy(d_busy), .tx_done(d_done), .fifo_count(d_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      line = 1'b1;
      done = 1'b0;
      busy = 1'b0;
      case (sel)
         2'd0: begin line = a_tx; done = a_done; busy = a_busy; end
         2'd1: begin line = b_tx; done = b_done; busy = b_busy; end
         2'd2: begin line = c_tx; done = c_done; busy = c_busy; end
         default: begin line = d_tx; done = d_done; busy = d_busy; end
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [7:0] d);
      a_data  = d;
      a_valid = 1'b1;
      tick(1);
      a_valid = 1'b0;
   endtask

   // 8N1 frame bit sequence, index 0 = start bit.
   function automatic logic [15:0] f8n1(input logic [7:0] d);
      return {6'b0, 1'b1, d, 1'b0};
   endfunction

   // Entered just after the edge where the start bit appears on the line.
   task automatic frame(input string tag, input logic [15:0] bits, input int n, input logic exp_busy);
      for (int i = 0; i < n; i++) begin
         chk({tag, "_bit_first"}, line, bits[i]);
         tick(159);
         chk({tag, "_bit_last"}, line, bits[i]);
         if (i == n - 1) chk({tag, "_done_early"}, done, 1'b0);
         tick(1);
      end
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_busy_end"}, busy, exp_busy);
   endtask

   initial begin
      int bad;
      rst = 1'b1; sel = 2'd0; a_en = 1'b1;
      a_data = '0; b_data = '0; c_data = '0; d_data = '0;
      a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0; d_valid = 1'b0;

      // Reset values
      tick(2);
      chk("rst_tx", a_tx, 1'b1);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_done", a_done, 1'b0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_ready", a_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("rst_ready_after", a_ready, 1'b1);
      tick(1);

      // 8N1 single frame, latency and boundaries
      push_a(8'hA5);
      chk("t1_cnt_E", a_cnt, 1);
      chk("t1_busy_E", a_busy, 1'b0);
      chk("t1_tx_E", a_tx, 1'b1);
      tick(1);
      chk("t1_busy_E1", a_busy, 1'b1);
      chk("t1_cnt_E1", a_cnt, 0);
      chk("t1_tx_E1", a_tx, 1'b1);
      tick(1);
      frame("t1", 16'b0000_0011_0100_1010, 10, 1'b0);
      tick(1);
      chk("t1_done_pulse", a_done, 1'b0);
      chk("t1_idle_tx", a_tx, 1'b1);
      tick(20);

      // FIFO full with tx_en low, then back-to-back drain
      a_en = 1'b0;
      push_a(8'h11); push_a(8'h12); push_a(8'h13); push_a(8'h14);
      chk("t3_cnt_full", a_cnt, 4);
      chk("t3_ready_full", a_ready, 1'b0);
      a_data = 8'h15; a_valid = 1'b1;
      tick(3);
      chk("t3_cnt_hold", a_cnt, 4);
      chk("t3_busy_hold", a_busy, 1'b0);
      chk("t3_tx_hold", a_tx, 1'b1);
      a_en = 1'b1;
      tick(1);
      chk("t3_cnt_pop", a_cnt, 3);
      chk("t3_ready_pop", a_ready, 1'b1);
      chk("t3_busy_pop", a_busy, 1'b1);
      tick(1);
      a_valid = 1'b0;
      chk("t3_cnt_refill", a_cnt, 4);
      chk("t3_ready_refill", a_ready, 1'b0);
      for (int k = 0; k < 5; k++) frame("t3", f8n1(8'h11 + 8'(k)), 10, k < 4);
      chk("t3_cnt_empty", a_cnt, 0);
      tick(20);

      // tx_en dropped mid-frame: frame completes, rest stays queued
      push_a(8'h31); push_a(8'h32); push_a(8'h33);
      chk("t5_cnt", a_cnt, 2);
      a_en = 1'b0;
      frame("t5a", f8n1(8'h31), 10, 1'b0);
      chk("t5_cnt_after", a_cnt, 2);
      tick(200);
      chk("t5_idle_tx", a_tx, 1'b1);
      chk("t5_idle_busy", a_busy, 1'b0);
      chk("t5_idle_cnt", a_cnt, 2);
      a_en = 1'b1;
      tick(1);
      chk("t5_restart_busy", a_busy, 1'b1);
      chk("t5_restart_tx", a_tx, 1'b1);
      chk("t5_restart_cnt", a_cnt, 1);
      tick(1);
      frame("t5b", f8n1(8'h32), 10, 1'b1);
      frame("t5c", f8n1(8'h33), 10, 1'b0);
      tick(20);

      // Reset mid-DATA with three words queued
      push_a(8'h21); push_a(8'h22); push_a(8'h23); push_a(8'h24);
      chk("t4_cnt", a_cnt, 3);
      tick(400);
      chk("t4_busy_pre", a_busy, 1'b1);
      rst = 1'b1;
      tick(1);
      chk("t4_tx", a_tx, 1'b1);
      chk("t4_busy", a_busy, 1'b0);
      chk("t4_cnt_clr", a_cnt, 0);
      chk("t4_ready_rst", a_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("t4_ready_after", a_ready, 1'b1);
      bad = 0;
      for (int i = 0; i < 1700; i++) begin
         tick(1);
         if (a_done !== 1'b0 || a_tx !== 1'b1 || a_busy !== 1'b0) bad = 1;
      end
      chk("t4_quiet", bad, 0);

      // Even and odd parity, 0x07
      sel = 2'd1;
      b_data = 8'h07; b_valid = 1'b1; tick(1); b_valid = 1'b0;
      tick(2);
      frame("t2_even", 16'b0000_0110_0000_1110, 11, 1'b0);
      sel = 2'd2;
      c_data = 8'h07; c_valid = 1'b1; tick(1); c_valid = 1'b0;
      tick(2);
      frame("t2_odd", 16'b0000_0100_0000_1110, 11, 1'b0);

      // 7 data bits, 2 stop bits, 0x55
      sel = 2'd3;
      d_data = 7'h55; d_valid = 1'b1; tick(1); d_valid = 1'b0;
      tick(2);
      frame("t6", 16'b0000_0011_1010_1010, 10, 1'b0);
      chk("t6_cnt", d_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
